// File: rtl/md_sequencer_pkg.sv
// Shared opcode constants, FSM state type and opcode classifiers for the
// multiply/divide sequencer.
package md_sequencer_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;

  typedef enum logic {
    MDS_IDLE = 1'b0,
    MDS_RUN  = 1'b1
  } mds_state_e;

  // Opcodes that start a multi-cycle operation
  function automatic logic is_launch_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  // Multiplies use the shorter latency
  function automatic logic is_mult_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath producing the 64-bit {hi,lo} result,
// including the divide-by-zero and signed-overflow corner cases.
module md_arith
  import md_sequencer_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_d1,
  input  logic [31:0] i_d2,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  logic signed [31:0] w_sa;
  logic signed [31:0] w_sb;
  logic signed [63:0] w_sprod;
  logic        [63:0] w_uprod;
  logic signed [31:0] w_squot;
  logic signed [31:0] w_srem;
  logic        [31:0] w_uquot;
  logic        [31:0] w_urem;
  logic               w_dz;
  logic               w_ovf;

  assign w_sa    = $signed(i_d1);
  assign w_sb    = $signed(i_d2);
  assign w_sprod = 64'(w_sa) * 64'(w_sb);
  assign w_uprod = {32'd0, i_d1} * {32'd0, i_d2};
  assign w_squot = w_sa / w_sb;
  assign w_srem  = w_sa % w_sb;
  assign w_uquot = i_d1 / i_d2;
  assign w_urem  = i_d1 % i_d2;
  assign w_dz    = (i_d2 == 32'd0);
  // Most-negative / -1 does not fit in 32 bits; the quotient wraps back to itself
  assign w_ovf   = (i_d1 == 32'h8000_0000) && (i_d2 == 32'hFFFF_FFFF);

  // Select the result for the requested operation
  always_comb begin
    o_hi = 32'd0;
    o_lo = 32'd0;
    case (i_op)
      MDU_MULT:  {o_hi, o_lo} = w_sprod;
      MDU_MULTU: {o_hi, o_lo} = w_uprod;
      MDU_DIV: begin
        if (w_dz) begin
          o_hi = i_d1;
          o_lo = 32'hFFFF_FFFF;
        end else if (w_ovf) begin
          o_hi = 32'd0;
          o_lo = 32'h8000_0000;
        end else begin
          o_hi = w_srem;
          o_lo = w_squot;
        end
      end
      MDU_DIVU: begin
        if (w_dz) begin
          o_hi = i_d1;
          o_lo = 32'hFFFF_FFFF;
        end else begin
          o_hi = w_urem;
          o_lo = w_uquot;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer owning the architectural HI/LO pair.
// The result is computed at launch and held in pending registers; HI/LO only
// change when the busy window expires (or on a direct mthi/mtlo while idle).
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] LP_MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] LP_DIV_CNT  = 4'(DIV_CYCLES);

  mds_state_e  r_state;
  mds_state_e  w_state_nxt;
  logic [3:0]  r_cnt;
  logic [31:0] r_ph;
  logic [31:0] r_pl;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        w_launch;
  logic        w_commit;
  logic        w_wr_hi;
  logic        w_wr_lo;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  md_arith u_arith (
    .i_op (MDUOp),
    .i_d1 (D1),
    .i_d2 (D2),
    .o_hi (w_res_hi),
    .o_lo (w_res_lo)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= MDS_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and per-cycle actions; every input is ignored while running
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_commit    = 1'b0;
    w_wr_hi     = 1'b0;
    w_wr_lo     = 1'b0;
    case (r_state)
      MDS_IDLE: begin
        if (Start && is_launch_op(MDUOp)) begin
          w_launch    = 1'b1;
          w_state_nxt = MDS_RUN;
        end else if (MDUOp == MDU_MTHI) begin
          w_wr_hi = 1'b1;
        end else if (MDUOp == MDU_MTLO) begin
          w_wr_lo = 1'b1;
        end
      end
      MDS_RUN: begin
        if (r_cnt == 4'd1) begin
          w_commit    = 1'b1;
          w_state_nxt = MDS_IDLE;
        end
      end
      default: w_state_nxt = MDS_IDLE;
    endcase
  end

  // Latency counter and pending result captured at launch
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 4'd0;
      r_ph  <= 32'd0;
      r_pl  <= 32'd0;
    end else if (w_launch) begin
      r_cnt <= is_mult_op(MDUOp) ? LP_MULT_CNT : LP_DIV_CNT;
      r_ph  <= w_res_hi;
      r_pl  <= w_res_lo;
    end else if (r_state == MDS_RUN) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Architectural HI/LO: commit from pending, or direct move while idle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_commit) begin
      r_hi <= r_ph;
      r_lo <= r_pl;
    end else begin
      if (w_wr_hi) r_hi <= D1;
      if (w_wr_lo) r_lo <= D1;
    end
  end

  assign Busy = (r_state == MDS_RUN);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: the driver advances a cycle-level
// behavioural model and queues the expected {Busy,HI,LO} after each edge; a
// monitor pops and compares on the falling edge.
module tb_md_sequencer;
  import md_sequencer_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  MDUOp;
  logic        Start;
  logic [31:0] D1;
  logic [31:0] D2;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  always #5 clk = ~clk;

  md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .MDUOp (MDUOp),
    .Start (Start),
    .D1    (D1),
    .D2    (D2),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  typedef struct {
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    int          step;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   step  = 0;

  // Reference state: remaining busy cycles and architectural/pending values
  int          m_rem = 0;
  logic [31:0] m_hi  = 0;
  logic [31:0] m_lo  = 0;
  logic [31:0] m_ph  = 0;
  logic [31:0] m_pl  = 0;

  function automatic logic [63:0] ref_result(input logic [3:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint          q;
    longint          r;
    longint unsigned uq;
    longint unsigned ur;
    logic [63:0]     res;
    res = 64'd0;
    if (op == MDU_MULT) res = 64'(sa * sb);
    else if (op == MDU_MULTU) res = ua * ub;
    else if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
    else if (op == MDU_DIV) begin
      q = sa / sb;
      r = sa % sb;
      res = {r[31:0], q[31:0]};
    end else begin
      uq = ua / ub;
      ur = ua % ub;
      res = {ur[31:0], uq[31:0]};
    end
    return res;
  endfunction

  task automatic cycle(input logic rst, input logic [3:0] op, input logic st,
                       input logic [31:0] a, input logic [31:0] b);
    reset = rst;
    MDUOp = op;
    Start = st;
    D1    = a;
    D2    = b;
    if (rst) begin
      m_rem = 0; m_hi = 0; m_lo = 0; m_ph = 0; m_pl = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_hi = m_ph;
        m_lo = m_pl;
      end
    end else if (st && (op >= MDU_MULT) && (op <= MDU_DIVU)) begin
      {m_ph, m_pl} = ref_result(op, a, b);
      m_rem = (op <= MDU_MULTU) ? MC : DC;
    end else if (op == MDU_MTHI) begin
      m_hi = a;
    end else if (op == MDU_MTLO) begin
      m_lo = a;
    end
    @(posedge clk);
    sb_q.push_back('{m_rem > 0, m_hi, m_lo, step});
    step++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, MDU_NONE, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic chk(input string name, input int stp,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, stp, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs with the queued expectation each cycle
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("busy", e.step, {31'd0, Busy}, {31'd0, e.busy});
      chk("hi",   e.step, HI, e.hi);
      chk("lo",   e.step, LO, e.lo);
    end
  end

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = $urandom_range(0, 20);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    cycle(1'b1, MDU_NONE, 1'b0, 32'd0, 32'd0);
    cycle(1'b1, MDU_MULT, 1'b1, 32'd9, 32'd9);
    idle(2);

    // Signed multiply of -2 by 3
    cycle(1'b0, MDU_MULT, 1'b1, 32'hFFFF_FFFE, 32'd3);
    idle(7);
    // Divides, including divide by zero and the overflow case
    cycle(1'b0, MDU_DIVU, 1'b1, 32'd7, 32'd2);
    idle(12);
    cycle(1'b0, MDU_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2);
    idle(12);
    cycle(1'b0, MDU_DIV, 1'b1, 32'd5, 32'd0);
    idle(12);
    cycle(1'b0, MDU_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(12);
    cycle(1'b0, MDU_MULTU, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(7);
    // Direct moves, and a move issued while running
    cycle(1'b0, MDU_MTHI, 1'b0, 32'h1234, 32'd0);
    idle(2);
    cycle(1'b0, MDU_MULT, 1'b1, 32'd6, 32'd7);
    cycle(1'b0, MDU_MTLO, 1'b0, 32'hDEAD, 32'd0);
    cycle(1'b0, MDU_MTHI, 1'b1, 32'hBEEF, 32'd0);
    idle(6);
    // Reset in the middle of an operation
    cycle(1'b0, MDU_MULT, 1'b1, 32'd100, 32'd3);
    idle(2);
    cycle(1'b1, MDU_NONE, 1'b0, 32'd0, 32'd0);
    idle(8);
    // Start held high through the busy window and into a back-to-back launch
    for (int i = 0; i < 7; i++) cycle(1'b0, MDU_MULT, 1'b1, 32'(i + 2), 32'(i + 11));
    idle(7);
    // Start with non-launching opcodes is ignored
    cycle(1'b0, MDU_MFHI, 1'b1, 32'd1, 32'd2);
    cycle(1'b0, MDU_MFLO, 1'b1, 32'd1, 32'd2);
    cycle(1'b0, MDU_NONE, 1'b1, 32'd1, 32'd2);
    idle(2);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 99) == 0, 4'($urandom_range(0, 8)),
            $urandom_range(0, 2) != 0, pick_operand(), pick_operand());
    end
    idle(12);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
